median_frame_ctrl: RTL and testbench
====================================

MEDIAN_FRAME_CTRL -- requirements
Module: median_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_LEN, default 1080, meaning pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 720, meaning lines per frame.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 64, meaning max DRAIN cycles before error.
REQ-004 SHALL have parameter CLEAR_CYCLES, default 2, meaning filter reset pulse length.
REQ-005 SHALL have ports, one per line:
  clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
  rst  input  1  synchronous active-high reset.
  start_i  input  1  frame start request.
  abort_i  input  1  abandon current frame.
  src_valid_i  input  1  source pixel valid.
  src_pixel_i  input  24  source pixel (pixel_t).
  src_ready_o  output  1  controller accepts source pixel.
  filt_rst_o  output  1  reset to median filter.
  filt_valid_o  output  1  pixel valid to filter.
  filt_pixel_o  output  24  pixel to filter.
  filt_out_valid_i  input  1  filter output valid.
  busy_o  output  1  frame in progress.
  done_o  output  1  one-cycle frame-complete pulse.
  err_o  output  1  sticky drain-timeout error.

Function
REQ-006 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-007 IDLE: start_i=1 -> CLEAR next cycle; otherwise stay.
REQ-008 CLEAR: filt_rst_o=1 for exactly CLEAR_CYCLES cycles, in/out counters zeroed, then -> STREAM.
REQ-009 STREAM: src_ready_o=1; filt_valid_o = src_valid_i (combinational, zero latency); filt_pixel_o = src_pixel_i.
REQ-010 Outside STREAM: src_ready_o=0, filt_valid_o=0, filt_pixel_o=0.
REQ-011 In-counter SHALL increment on each accepted pixel (src_valid_i & src_ready_o); width $clog2(IMAGE_LEN*IMAGE_HEIGHT+1).
REQ-012 Accept with in-count = IMAGE_LEN*IMAGE_HEIGHT-1 -> DRAIN next cycle; no further acceptance.
REQ-013 Out-counter SHALL increment on filt_out_valid_i in STREAM and DRAIN; expected total (IMAGE_LEN-1)*(IMAGE_HEIGHT-1).
REQ-014 DRAIN: out-count (including the current cycle's valid) reaching expected total -> DONE; timeout counter reaching DRAIN_TIMEOUT first -> set err_o, -> DONE.
REQ-015 DONE: done_o=1 for exactly one cycle, -> IDLE.
REQ-016 busy_o=1 in CLEAR, STREAM, DRAIN, DONE; 0 in IDLE.
REQ-017 start_i while busy_o=1 SHALL be ignored (not queued).
REQ-018 abort_i in any non-IDLE state -> CLEAR-then-IDLE: filt_rst_o CLEAR_CYCLES cycles, no done_o, err_o unchanged.
REQ-019 abort_i and start_i same cycle in IDLE: start wins.
REQ-020 err_o sticky; cleared only by rst or next accepted start_i.
REQ-021 filt_out_valid_i outside STREAM/DRAIN SHALL be ignored.

Reset
REQ-022 rst SHALL force IDLE, counters 0, src_ready_o=0, filt_valid_o=0, filt_pixel_o=0, busy_o=0, done_o=0, err_o=0.
REQ-023 rst SHALL force filt_rst_o=1 while asserted; 0 the cycle after release.
REQ-024 rst mid-frame SHALL discard all frame state; no done_o issued.

Structure
REQ-025 pixel_t (24-bit red/green/blue, 8 bits each) and ctrl_state_t enum SHALL live in median_filter_pkg.
REQ-026 Controller SHALL be a single module with no sub-modules; median_filter is instantiated by the parent, not here.

Verification (IMAGE_LEN=4, IMAGE_HEIGHT=3, DRAIN_TIMEOUT=8, CLEAR_CYCLES=2)
REQ-027 start_i pulse, 12 back-to-back valid pixels, filter model returns 6 valids -> filt_rst_o 2 cycles, 12 filt_valid_o, done_o one cycle, err_o=0.
REQ-028 Source valid toggling 50% -> exactly 12 accepts, src_ready_o=0 after 12th, done_o once.
REQ-029 Filter model returns only 5 valids -> DRAIN 8 cycles, err_o=1, done_o pulse, IDLE; next start_i clears err_o.
REQ-030 abort_i after 5th accepted pixel -> filt_rst_o 2 cycles, IDLE, no done_o, busy_o=0.
REQ-031 start_i asserted during STREAM -> ignored; exactly one done_o for the frame.
REQ-032 rst asserted during DRAIN -> all outputs at reset values next cycle, filt_rst_o=1 while rst held.

Source files
------------

// File: rtl/median_filter_pkg.sv
// Shared types for the median filter datapath and its frame controller.
package median_filter_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the median filter: clears the filter, streams one frame of
// pixels into it, waits for the filter to drain, then reports completion or timeout.
module median_frame_ctrl
  import median_filter_pkg::*;
#(
  parameter int IMAGE_LEN     = 1080,
  parameter int IMAGE_HEIGHT  = 720,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        src_valid_i,
  input  logic [23:0] src_pixel_i,
  output logic        src_ready_o,
  output logic        filt_rst_o,
  output logic        filt_valid_o,
  output logic [23:0] filt_pixel_o,
  input  logic        filt_out_valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int NPIX  = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int NOUT  = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] out_sum;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  pixel_t           pix_in;

  assign pix_in = pixel_t'(src_pixel_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clr_cnt_q <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    abort_d      = abort_q;
    err_d        = err_q;
    src_ready_o  = 1'b0;
    filt_valid_o = 1'b0;
    filt_pixel_o = '0;
    // Drain completion counts the valid arriving in the current cycle.
    out_sum      = out_cnt_q + CNT_W'(filt_out_valid_i);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          abort_d   = 1'b0;
          err_d     = 1'b0;
        end
      end
      CLEAR: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        tmo_cnt_d = '0;
        if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
          clr_cnt_d = '0;
          state_d   = abort_q ? IDLE : STREAM;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      STREAM: begin
        src_ready_o  = 1'b1;
        filt_valid_o = src_valid_i;
        filt_pixel_o = pix_in;
        if (filt_out_valid_i) out_cnt_d = out_sum;
        if (src_valid_i) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(NPIX - 1)) begin
            state_d   = DRAIN;
            tmo_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        out_cnt_d = out_sum;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (out_sum >= CNT_W'(NOUT)) begin
          state_d = DONE;
        end else if (tmo_cnt_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort re-runs the clear sequence and then parks in IDLE; error flag is kept.
    if (abort_i && (state_q != IDLE)) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      abort_d   = 1'b1;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      tmo_cnt_d = '0;
      err_d     = err_q;
    end
  end

  assign filt_rst_o = rst | (state_q == CLEAR);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Randomized scoreboard bench for median_frame_ctrl on a 4x3 frame.
module tb_median_frame_ctrl;

  localparam int L    = 4;
  localparam int H    = 3;
  localparam int TMO  = 8;
  localparam int CLR  = 2;
  localparam int NPIX = L * H;
  localparam int NOUT = (L - 1) * (H - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        src_valid_i = 1'b0;
  logic [23:0] src_pixel_i = '0;
  logic        filt_out_valid_i = 1'b0;
  logic        src_ready_o, filt_rst_o, filt_valid_o, busy_o, done_o, err_o;
  logic [23:0] filt_pixel_o;

  median_frame_ctrl #(
    .IMAGE_LEN(L), .IMAGE_HEIGHT(H), .DRAIN_TIMEOUT(TMO), .CLEAR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .src_valid_i(src_valid_i), .src_pixel_i(src_pixel_i), .src_ready_o(src_ready_o),
    .filt_rst_o(filt_rst_o), .filt_valid_o(filt_valid_o), .filt_pixel_o(filt_pixel_o),
    .filt_out_valid_i(filt_out_valid_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  logic [23:0] px_q[$];
  done_t       done_q[$];
  int          rstrun_q[$];
  done_t       dexp;
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  int          run = 0;
  bit          err_model = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected pixels, done pulses and filter-reset pulse lengths.
  always @(negedge clk) begin
    if (mon_en) begin
      if (filt_valid_o) begin
        if (px_q.size() == 0) chk("pixel_extra", 32'(filt_valid_o), 0);
        else chk("pixel", 32'(filt_pixel_o), 32'(px_q.pop_front()));
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("done_extra", 32'(done_o), 0);
        else begin
          dexp = done_q.pop_front();
          chk("done_cycle", cyc, dexp.cyc);
          chk("done_err", 32'(err_o), 32'(dexp.err));
        end
      end
      if (filt_rst_o) run++;
      else if (run != 0) begin
        if (rstrun_q.size() == 0) chk("filt_rst_extra", run, 0);
        else chk("filt_rst_len", run, rstrun_q.pop_front());
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_valid_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    filt_out_valid_i = 1'b0;
  endtask

  // One frame: pct = source valid probability, nval = filter outputs returned,
  // abort_after = abort after that many accepts (0 none), rst_at = drain cycle to reset (-1 none).
  task automatic run_frame(input int pct, input int nval, input bit start_in_stream,
                           input int abort_after, input int rst_at);
    int acc, sv, budget, rem, tot, dcyc, guard;
    bit fin;
    #1;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_err", 32'(err_o), 32'(err_model));
    start_i = 1'b1;
    abort_i = ($urandom_range(1, 0) == 1);
    rstrun_q.push_back(CLR);
    tick;
    start_i = 1'b0;
    abort_i = 1'b0;
    filt_out_valid_i = 1'b1;
    err_model = 1'b0;
    #1;
    chk("clear_err", 32'(err_o), 0);
    chk("clear_busy", 32'(busy_o), 1);
    tick;
    tick;
    filt_out_valid_i = 1'b0;

    budget = int'($urandom_range(3, 0));
    if (budget > nval) budget = nval;
    acc = 0; sv = 0; guard = 0;
    while (acc < NPIX && guard < 400) begin
      guard++;
      src_valid_i = (int'($urandom_range(99, 0)) < pct);
      src_pixel_i = 24'($urandom);
      start_i = start_in_stream && ($urandom_range(2, 0) == 0);
      filt_out_valid_i = (sv < budget) && ($urandom_range(1, 0) == 1);
      if (filt_out_valid_i) sv++;
      if (src_valid_i) begin
        px_q.push_back(src_pixel_i);
        acc++;
      end
      tick;
      if (abort_after != 0 && acc == abort_after) begin
        idle_inputs();
        abort_i = 1'b1;
        rstrun_q.push_back(CLR);
        tick;
        abort_i = 1'b0;
        tick;
        tick;
        #1;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_err", 32'(err_o), 32'(err_model));
        chk("abort_ready", 32'(src_ready_o), 0);
        return;
      end
    end
    if (acc < NPIX) chk("stream_guard", acc, NPIX);

    idle_inputs();
    src_valid_i = (pct < 100);
    src_pixel_i = 24'($urandom);
    rem = nval - sv;
    tot = sv;
    dcyc = cyc;
    fin = 1'b0;
    #1;
    chk("drain_ready", 32'(src_ready_o), 0);
    chk("drain_fvalid", 32'(filt_valid_o), 0);
    for (int i = 0; i < TMO && !fin; i++) begin
      filt_out_valid_i = (rem > 0);
      if (rem > 0) begin
        rem--;
        tot++;
      end
      if (i == rst_at) begin
        filt_out_valid_i = 1'b0;
        rst = 1'b1;
        rstrun_q.push_back(2);
        tick;
        #1;
        chk("rst_filt_rst", 32'(filt_rst_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ready", 32'(src_ready_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_pixel", 32'(filt_pixel_o), 0);
        tick;
        rst = 1'b0;
        src_valid_i = 1'b0;
        err_model = 1'b0;
        #1;
        chk("rel_filt_rst", 32'(filt_rst_o), 0);
        chk("rel_busy", 32'(busy_o), 0);
        chk("rel_fvalid", 32'(filt_valid_o), 0);
        return;
      end
      if (tot >= NOUT) begin
        done_q.push_back('{dcyc + i + 1, 1'b0});
        fin = 1'b1;
      end else if (i == TMO - 1) begin
        done_q.push_back('{dcyc + i + 1, 1'b1});
        err_model = 1'b1;
        fin = 1'b1;
      end
      tick;
    end
    idle_inputs();
    tick;
  endtask

  initial begin
    tick;
    tick;
    chk("por_filt_rst", 32'(filt_rst_o), 1);
    chk("por_busy", 32'(busy_o), 0);
    rst = 1'b0;
    #1;
    chk("por_rel_filt_rst", 32'(filt_rst_o), 0);
    chk("por_ready", 32'(src_ready_o), 0);
    chk("por_fvalid", 32'(filt_valid_o), 0);
    chk("por_pixel", 32'(filt_pixel_o), 0);
    chk("por_done", 32'(done_o), 0);
    chk("por_err", 32'(err_o), 0);
    mon_en = 1'b1;
    tick;

    run_frame(100, 6, 1'b0, 0, -1);
    run_frame(50, 6, 1'b0, 0, -1);
    run_frame(70, 5, 1'b0, 0, -1);
    run_frame(60, 6, 1'b0, 5, -1);
    run_frame(60, 6, 1'b1, 0, -1);
    run_frame(80, 5, 1'b0, 0, 3);
    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(100, 30)), 5 + int'($urandom_range(1, 0)),
                ($urandom_range(1, 0) == 1), 0, -1);

    idle_inputs();
    repeat (4) tick;
    chk("px_q_left", px_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("rstrun_q_left", rstrun_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
